player_select: RTL

Upstream feeder for the game controller FSM. Captures each player's animal choice (dog/cat/chicken), locks both choices, and presents the round as one of nine registered one-hot scenario signals until the controller acknowledges it. After each round it judges the result, updates the two 2-bit scores, and flags the game winner when a score reaches WIN_SCORE.

---
 rtl/player_select.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/player_select.sv
// ---------------------------------------------------------------------------
// player_select
//
// Upstream feeder for the game controller. Each player cycles through an
// animal choice (dog -> cat -> chicken -> dog) and locks it in. Once both
// players are locked, the round is presented as one of nine registered
// one-hot scenario bits, with roundValid, until the controller acknowledges
// it. A single scoring cycle then judges the round, updates the saturating
// 2-bit scores, releases the locks and, when a score reaches WIN_SCORE,
// raises the winner flag and parks in GAMEOVER until newGame.
//
// Parameters
//   WIN_SCORE      points needed to win the game (legal range 1..3)
//
// Ports
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   p1Key/p2Key    choice-cycle requests, act on their rising edge
//   p1Lock/p2Lock  lock requests, act on their rising edge
//   roundAck       controller consumed the scenario (level, READY only)
//   newGame        restart after game over (level, GAMEOVER only)
//   <a><b>         nine one-hot scenario outputs, a = p1 animal, b = p2 animal
//   roundValid     scenario outputs are valid
//   p1Choice/p2Choice  current choice: 00 dog, 01 cat, 10 chicken
//   p1Locked/p2Locked  lock status
//   p1Score/p2Score    scores
//   winner1/winner2    game-winner flags
//   gameOver       high while in GAMEOVER
// ---------------------------------------------------------------------------
module player_select #(
    parameter int WIN_SCORE = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       p1Key,
    input  logic       p2Key,
    input  logic       p1Lock,
    input  logic       p2Lock,
    input  logic       roundAck,
    input  logic       newGame,
    output logic       dogDog,
    output logic       dogCat,
    output logic       dogChicken,
    output logic       catDog,
    output logic       catCat,
    output logic       catChicken,
    output logic       chickenDog,
    output logic       chickenCat,
    output logic       chickenChicken,
    output logic       roundValid,
    output logic [1:0] p1Choice,
    output logic [1:0] p2Choice,
    output logic       p1Locked,
    output logic       p2Locked,
    output logic [1:0] p1Score,
    output logic [1:0] p2Score,
    output logic       winner1,
    output logic       winner2,
    output logic       gameOver
);

    localparam logic [1:0] LP_WIN     = 2'(WIN_SCORE);
    localparam logic [1:0] CH_DOG     = 2'd0;
    localparam logic [1:0] CH_CAT     = 2'd1;
    localparam logic [1:0] CH_CHICKEN = 2'd2;

    typedef enum logic [1:0] {
        ST_SELECT   = 2'd0,
        ST_READY    = 2'd1,
        ST_SCORE    = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Next animal in the cycle. The same ordering also defines who beats
    // whom: an animal beats the one that follows it.
    function automatic logic [1:0] f_next_choice(input logic [1:0] c);
        logic [1:0] n;
        case (c)
            CH_DOG:     n = CH_CAT;
            CH_CAT:     n = CH_CHICKEN;
            CH_CHICKEN: n = CH_DOG;
            default:    n = CH_DOG;
        endcase
        return n;
    endfunction

    function automatic logic f_beats(input logic [1:0] a, input logic [1:0] b);
        return (b == f_next_choice(a));
    endfunction

    // -----------------------------------------------------------------------
    // Rising-edge detection. Previous values reset to 1 so that an input
    // already high when reset releases is not mistaken for a fresh press.
    // Bit order: {p2Lock, p1Lock, p2Key, p1Key}.
    // -----------------------------------------------------------------------
    logic [3:0] w_in_raw;
    logic [3:0] r_in_prev;
    logic [3:0] w_in_rise;
    logic [1:0] w_key_rise;
    logic [1:0] w_lock_rise;

    assign w_in_raw = {p2Lock, p1Lock, p2Key, p1Key};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_prev <= '1;
        end else begin
            r_in_prev <= w_in_raw;
        end
    end

    assign w_in_rise   = w_in_raw & ~r_in_prev;
    assign w_key_rise  = w_in_rise[1:0];
    assign w_lock_rise = w_in_rise[3:2];

    // -----------------------------------------------------------------------
    // Per-player view shared with the control logic. Index 0 is player 1.
    // -----------------------------------------------------------------------
    logic [1:0][1:0] w_choice;
    logic [1:0][1:0] w_score;
    logic [1:0][1:0] w_score_inc;
    logic [1:0]      w_locked;
    logic [1:0]      w_locked_sel;   // lock status after this cycle's lock edge
    logic [1:0]      w_winner;
    logic [1:0]      w_beats;        // player won the round being scored
    logic [1:0]      w_hits_win;     // that win reaches WIN_SCORE
    logic            w_game_won;

    assign w_beats[0] = f_beats(w_choice[0], w_choice[1]);
    assign w_beats[1] = f_beats(w_choice[1], w_choice[0]);
    assign w_game_won = |w_hits_win;

    // -----------------------------------------------------------------------
    // Control strobes decoded from the current state (output process).
    // -----------------------------------------------------------------------
    logic w_sel_active;
    logic w_round_start;
    logic w_round_clear;
    logic w_score_now;
    logic w_restart;

    always_comb begin
        w_sel_active  = 1'b0;
        w_round_start = 1'b0;
        w_round_clear = 1'b0;
        w_score_now   = 1'b0;
        w_restart     = 1'b0;
        gameOver      = 1'b0;
        case (r_state)
            ST_SELECT: begin
                w_sel_active  = 1'b1;
                w_round_start = &w_locked_sel;
            end
            ST_READY: begin
                w_round_clear = roundAck;
            end
            ST_SCORE: begin
                w_score_now = 1'b1;
            end
            ST_GAMEOVER: begin
                gameOver  = 1'b1;
                w_restart = newGame;
            end
            default: begin
                w_sel_active = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and next-state logic.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_SELECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SELECT: begin
                // The second lock moves straight to READY on its own edge.
                if (&w_locked_sel) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (roundAck) begin
                    w_state_next = ST_SCORE;
                end
            end
            ST_SCORE: begin
                w_state_next = w_game_won ? ST_GAMEOVER : ST_SELECT;
            end
            ST_GAMEOVER: begin
                if (newGame) begin
                    w_state_next = ST_SELECT;
                end
            end
            default: begin
                w_state_next = ST_SELECT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Per-player choice, lock, score and winner registers.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            logic [1:0] r_choice;
            logic [1:0] r_score;
            logic       r_locked;
            logic       r_winner;

            assign w_locked_sel[gi] = r_locked | w_lock_rise[gi];
            assign w_score_inc[gi]  = (r_score == 2'd3) ? 2'd3 : r_score + 2'd1;
            assign w_hits_win[gi]   = w_beats[gi] && (w_score_inc[gi] == LP_WIN);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_choice <= CH_DOG;
                    r_score  <= 2'd0;
                    r_locked <= 1'b0;
                    r_winner <= 1'b0;
                end else begin
                    // A lock edge wins over a simultaneous key edge.
                    if (w_sel_active && !r_locked) begin
                        if (w_lock_rise[gi]) begin
                            r_locked <= 1'b1;
                        end else if (w_key_rise[gi]) begin
                            r_choice <= f_next_choice(r_choice);
                        end
                    end
                    if (w_score_now) begin
                        r_locked <= 1'b0;
                        if (w_beats[gi]) begin
                            r_score <= w_score_inc[gi];
                        end
                        if (w_hits_win[gi]) begin
                            r_winner <= 1'b1;
                        end
                    end
                    if (w_restart) begin
                        r_choice <= CH_DOG;
                        r_score  <= 2'd0;
                        r_winner <= 1'b0;
                    end
                end
            end

            assign w_choice[gi] = r_choice;
            assign w_score[gi]  = r_score;
            assign w_locked[gi] = r_locked;
            assign w_winner[gi] = r_winner;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Scenario register. Index = p1 choice * 3 + p2 choice, so bit 0 is
    // dogDog and bit 8 is chickenChicken. Choices are already final when the
    // round starts: a locked player cannot advance and the locking edge
    // itself never advances the choice.
    // -----------------------------------------------------------------------
    logic [3:0] w_scen_idx;
    logic [8:0] w_scen_onehot;
    logic [8:0] r_scenario;
    logic       r_round_valid;

    assign w_scen_idx = ({2'b00, w_choice[0]} * 4'd3) + {2'b00, w_choice[1]};

    generate
        for (gi = 0; gi < 9; gi++) begin : g_scen_decode
            assign w_scen_onehot[gi] = (w_scen_idx == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scenario    <= '0;
            r_round_valid <= 1'b0;
        end else if (w_round_start) begin
            r_scenario    <= w_scen_onehot;
            r_round_valid <= 1'b1;
        end else if (w_round_clear) begin
            r_scenario    <= '0;
            r_round_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping.
    // -----------------------------------------------------------------------
    assign dogDog         = r_scenario[0];
    assign dogCat         = r_scenario[1];
    assign dogChicken     = r_scenario[2];
    assign catDog         = r_scenario[3];
    assign catCat         = r_scenario[4];
    assign catChicken     = r_scenario[5];
    assign chickenDog     = r_scenario[6];
    assign chickenCat     = r_scenario[7];
    assign chickenChicken = r_scenario[8];
    assign roundValid     = r_round_valid;

    assign p1Choice = w_choice[0];
    assign p2Choice = w_choice[1];
    assign p1Locked = w_locked[0];
    assign p2Locked = w_locked[1];
    assign p1Score  = w_score[0];
    assign p2Score  = w_score[1];
    assign winner1  = w_winner[0];
    assign winner2  = w_winner[1];

endmodule
